// File: rtl/robot_motor_drive.sv
// Two-wheel motor driver: robot state -> per-wheel ramped duty, PWM, direction with dead time, brake.
// Latency: target registers one cycle after state; duty steps once per ramp tick; pwm/settled combinational from registers.
// Backpressure: none; free-running, ERROR/enable=0 force duty 0 on the next cycle.
module robot_motor_drive #(
    parameter int PWM_BITS    = 8,
    parameter int DUTY_MAX    = 200,
    parameter int TURN_DUTY   = 128,
    parameter int RAMP_STEP   = 8,
    parameter int RAMP_DIV    = 16,
    parameter int DEAD_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          state,
    input  logic                enable,
    output logic                pwm_l,
    output logic                pwm_r,
    output logic                dir_l,
    output logic                dir_r,
    output logic                brake,
    output logic [PWM_BITS-1:0] duty_l,
    output logic [PWM_BITS-1:0] duty_r,
    output logic                settled
);

    // Robot state codes, in the order the controller defines them.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FORWARD  = 3'd1;
    localparam logic [2:0] ST_BACKWARD = 3'd2;
    localparam logic [2:0] ST_LEFT     = 3'd3;
    localparam logic [2:0] ST_RIGHT    = 3'd4;
    localparam logic [2:0] ST_STOP     = 3'd5;
    localparam logic [2:0] ST_ERROR    = 3'd6;
    localparam logic [2:0] ST_RECOVER  = 3'd7;

    localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS+1)'(RAMP_STEP);

    typedef enum logic [1:0] {
        W_RUN   = 2'd0,
        W_DECEL = 2'd1,
        W_DEAD  = 2'd2
    } wheel_st_e;

    // Index 0 is the left wheel, index 1 the right wheel.
    logic [PWM_BITS-1:0] duty_q [2];
    logic [PWM_BITS-1:0] duty_d [2];
    logic                dir_q  [2];
    logic                dir_d  [2];
    wheel_st_e           wst_q  [2];
    wheel_st_e           wst_d  [2];
    logic [DEAD_W-1:0]   dead_q [2];
    logic [DEAD_W-1:0]   dead_d [2];
    logic                eff_dir [2];

    logic [DIV_W-1:0]    div_q, div_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                brake_q, brake_d;
    logic                tgt_hold_q, tgt_hold_d;
    logic [1:0]          tgt_dir_q, tgt_dir_d;
    logic [PWM_BITS-1:0] tgt_duty_q, tgt_duty_d;
    logic                tick;
    logic                force_zero;

    // One ramp step from cur toward tgt, clamping exactly at tgt.
    function automatic logic [PWM_BITS-1:0] ramp_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        logic [PWM_BITS:0]   sum;
        logic [PWM_BITS-1:0] res;
        sum = {1'b0, cur} + STEP_W;
        res = cur;
        if (cur < tgt) begin
            res = (sum > {1'b0, tgt}) ? tgt : sum[PWM_BITS-1:0];
        end else if (cur > tgt) begin
            res = ((cur - tgt) < STEP_W[PWM_BITS-1:0]) ? tgt : (cur - STEP_W[PWM_BITS-1:0]);
        end
        return res;
    endfunction

    assign tick       = (div_q == DIV_W'(RAMP_DIV - 1));
    assign force_zero = (state == ST_ERROR) || !enable;

    // Hold-type states keep each wheel's present direction as its target.
    assign eff_dir[0] = tgt_hold_q ? dir_q[0] : tgt_dir_q[0];
    assign eff_dir[1] = tgt_hold_q ? dir_q[1] : tgt_dir_q[1];

    // Target table decode; registered so the target lags state by one cycle.
    always_comb begin
        tgt_hold_d = 1'b1;
        tgt_dir_d  = 2'b11;
        tgt_duty_d = '0;
        case (state)
            ST_FORWARD:  begin tgt_hold_d = 1'b0; tgt_dir_d = 2'b11; tgt_duty_d = PWM_BITS'(DUTY_MAX);  end
            ST_BACKWARD: begin tgt_hold_d = 1'b0; tgt_dir_d = 2'b00; tgt_duty_d = PWM_BITS'(DUTY_MAX);  end
            ST_LEFT:     begin tgt_hold_d = 1'b0; tgt_dir_d = 2'b10; tgt_duty_d = PWM_BITS'(TURN_DUTY); end
            ST_RIGHT:    begin tgt_hold_d = 1'b0; tgt_dir_d = 2'b01; tgt_duty_d = PWM_BITS'(TURN_DUTY); end
            ST_IDLE, ST_STOP, ST_ERROR, ST_RECOVER: ;
            default: ;
        endcase
    end

    // Ramp divider, PWM counter and brake request.
    always_comb begin
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        cnt_d   = cnt_q + PWM_BITS'(1);
        brake_d = enable && ((state == ST_ERROR) ||
                  ((state == ST_STOP) && (duty_q[0] == '0) && (duty_q[1] == '0)));
    end

    // Per-wheel RUN/DECEL/DEAD sequencing; a forced stop overrides ramps and dead-time expiry.
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            duty_d[w] = duty_q[w];
            dir_d[w]  = dir_q[w];
            wst_d[w]  = wst_q[w];
            dead_d[w] = dead_q[w];
            if (force_zero) begin
                duty_d[w] = '0;
                wst_d[w]  = W_RUN;
                dead_d[w] = '0;
            end else begin
                case (wst_q[w])
                    W_RUN: begin
                        if (eff_dir[w] != dir_q[w]) begin
                            wst_d[w] = W_DECEL;
                        end else if (tick) begin
                            duty_d[w] = ramp_toward(duty_q[w], tgt_duty_q);
                        end
                    end
                    W_DECEL: begin
                        if (eff_dir[w] == dir_q[w]) begin
                            wst_d[w] = W_RUN;
                        end else if (duty_q[w] == '0) begin
                            wst_d[w]  = W_DEAD;
                            dead_d[w] = '0;
                        end else if (tick) begin
                            duty_d[w] = ramp_toward(duty_q[w], '0);
                        end
                    end
                    W_DEAD: begin
                        if (eff_dir[w] == dir_q[w]) begin
                            wst_d[w]  = W_RUN;
                            dead_d[w] = '0;
                        end else if (dead_q[w] == DEAD_W'(DEAD_CYCLES - 1)) begin
                            dir_d[w]  = eff_dir[w];
                            wst_d[w]  = W_RUN;
                            dead_d[w] = '0;
                        end else begin
                            dead_d[w] = dead_q[w] + DEAD_W'(1);
                        end
                    end
                    default: wst_d[w] = W_RUN;
                endcase
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            cnt_q      <= '0;
            brake_q    <= 1'b0;
            tgt_hold_q <= 1'b1;
            tgt_dir_q  <= 2'b11;
            tgt_duty_q <= '0;
            for (int w = 0; w < 2; w++) begin
                duty_q[w] <= '0;
                dir_q[w]  <= 1'b1;
                wst_q[w]  <= W_RUN;
                dead_q[w] <= '0;
            end
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            brake_q    <= brake_d;
            tgt_hold_q <= tgt_hold_d;
            tgt_dir_q  <= tgt_dir_d;
            tgt_duty_q <= tgt_duty_d;
            for (int w = 0; w < 2; w++) begin
                duty_q[w] <= duty_d[w];
                dir_q[w]  <= dir_d[w];
                wst_q[w]  <= wst_d[w];
                dead_q[w] <= dead_d[w];
            end
        end
    end

    // Outputs: PWM compare and settled status straight from registers.
    always_comb begin
        pwm_l   = (cnt_q < duty_q[0]);
        pwm_r   = (cnt_q < duty_q[1]);
        settled = (wst_q[0] == W_RUN) && (wst_q[1] == W_RUN) &&
                  (duty_q[0] == tgt_duty_q) && (duty_q[1] == tgt_duty_q) &&
                  (dir_q[0] == eff_dir[0]) && (dir_q[1] == eff_dir[1]);
    end

    assign dir_l  = dir_q[0];
    assign dir_r  = dir_q[1];
    assign duty_l = duty_q[0];
    assign duty_r = duty_q[1];
    assign brake  = brake_q;

endmodule

// File: tb/tb_robot_motor_drive.sv
// Bench for robot_motor_drive: directed scenarios plus random state/enable/reset traffic.
// Latency: model advances on each rising edge; outputs compared on every falling edge.
// Backpressure: none.
module tb_robot_motor_drive;

    localparam int IDLE = 0, FORWARD = 1, BACKWARD = 2, LEFT = 3, RIGHT = 4,
                   STOP = 5, ERROR = 6, RECOVER = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state;
    logic       enable;
    logic       pwm_l, pwm_r, dir_l, dir_r, brake, settled;
    logic [7:0] duty_l, duty_r;

    int n_checks = 0;
    int n_err    = 0;

    robot_motor_drive dut (
        .clk(clk), .rst(rst), .state(state), .enable(enable),
        .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
        .brake(brake), .duty_l(duty_l), .duty_r(duty_r), .settled(settled)
    );

    always #5 clk = ~clk;

    // Reference model: wheel mode 0=driving, 1=slowing for reversal, 2=waiting dead time.
    int m_duty [2];
    int m_dir  [2];
    int m_mode [2];
    int m_dead [2];
    int m_edges;
    int m_tstate;
    int m_brake;
    bit model_ok = 1'b0;

    function automatic int tgt_duty_of(input int s);
        if (s == FORWARD || s == BACKWARD) return 200;
        if (s == LEFT || s == RIGHT) return 128;
        return 0;
    endfunction

    // Desired direction for wheel w in state s, or -1 when the state keeps whatever it has.
    function automatic int tgt_dir_of(input int s, input int w);
        case (s)
            FORWARD:  return 1;
            BACKWARD: return 0;
            LEFT:     return (w == 0) ? 0 : 1;
            RIGHT:    return (w == 0) ? 1 : 0;
            default:  return -1;
        endcase
    endfunction

    function automatic int approach(input int c, input int t);
        if (c < t) return (c + 8 > t) ? t : c + 8;
        if (c > t) return (c - 8 < t) ? t : c - 8;
        return c;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 2; w++) begin
                m_duty[w] = 0; m_dir[w] = 1; m_mode[w] = 0; m_dead[w] = 0;
            end
            m_edges  = 0;
            m_tstate = IDLE;
            m_brake  = 0;
            model_ok = 1'b1;
        end else begin
            bit tick, forcez;
            tick   = ((m_edges % 16) == 15);
            forcez = (int'(state) == ERROR) || !enable;
            m_brake = (enable && (int'(state) == ERROR ||
                       (int'(state) == STOP && m_duty[0] == 0 && m_duty[1] == 0))) ? 1 : 0;
            for (int w = 0; w < 2; w++) begin
                int td, want;
                td   = tgt_dir_of(m_tstate, w);
                want = (td < 0) ? m_dir[w] : td;
                if (forcez) begin
                    m_duty[w] = 0; m_mode[w] = 0; m_dead[w] = 0;
                end else if (m_mode[w] == 0) begin
                    if (want != m_dir[w]) m_mode[w] = 1;
                    else if (tick) m_duty[w] = approach(m_duty[w], tgt_duty_of(m_tstate));
                end else if (m_mode[w] == 1) begin
                    if (want == m_dir[w]) m_mode[w] = 0;
                    else if (m_duty[w] == 0) begin m_mode[w] = 2; m_dead[w] = 0; end
                    else if (tick) m_duty[w] = approach(m_duty[w], 0);
                end else begin
                    if (want == m_dir[w]) begin m_mode[w] = 0; m_dead[w] = 0; end
                    else if (m_dead[w] == 31) begin m_dir[w] = want; m_mode[w] = 0; m_dead[w] = 0; end
                    else m_dead[w]++;
                end
            end
            m_tstate = int'(state);
            m_edges++;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            int e_pl, e_pr, e_set;
            e_pl  = ((m_edges % 256) < m_duty[0]) ? 1 : 0;
            e_pr  = ((m_edges % 256) < m_duty[1]) ? 1 : 0;
            e_set = 1;
            for (int w = 0; w < 2; w++) begin
                int td, want;
                td   = tgt_dir_of(m_tstate, w);
                want = (td < 0) ? m_dir[w] : td;
                if (m_mode[w] != 0 || m_duty[w] != tgt_duty_of(m_tstate) || m_dir[w] != want) e_set = 0;
            end
            n_checks++;
            if (int'(duty_l) != m_duty[0] || int'(duty_r) != m_duty[1] ||
                int'(dir_l) != m_dir[0] || int'(dir_r) != m_dir[1] ||
                int'(pwm_l) != e_pl || int'(pwm_r) != e_pr ||
                int'(brake) != m_brake || int'(settled) != e_set) begin
                n_err++;
                if (n_err < 30)
                    $display("FAIL model t=%0t: duty=%0d,%0d want %0d,%0d dir=%b%b want %0d%0d pwm=%b%b want %0d%0d brake=%b want %0d settled=%b want %0d",
                             $time, duty_l, duty_r, m_duty[0], m_duty[1], dir_l, dir_r, m_dir[0], m_dir[1],
                             pwm_l, pwm_r, e_pl, e_pr, brake, m_brake, settled, e_set);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_zero(input int maxc, input string nm);
        int i;
        i = 0;
        while ((duty_l != 8'd0 || duty_r != 8'd0) && i < maxc) begin
            @(negedge clk);
            i++;
        end
        check(nm, (duty_l == 8'd0 && duty_r == 8'd0) ? 1 : 0, 1);
    endtask

    initial begin
        int hi;
        rst = 1'b1; state = 3'(IDLE); enable = 1'b1;
        cyc(2);
        rst = 1'b0;
        check("reset duty_l", int'(duty_l), 0);
        check("reset dirs", int'({dir_l, dir_r}), 3);
        check("reset pwm", int'({pwm_l, pwm_r}), 0);
        check("reset brake", int'(brake), 0);
        check("reset settled", int'(settled), 1);

        // Forward ramp to full duty, then duty-cycle count.
        state = 3'(FORWARD);
        cyc(420);
        check("fwd duty_l", int'(duty_l), 200);
        check("fwd duty_r", int'(duty_r), 200);
        check("fwd settled", int'(settled), 1);
        hi = 0;
        repeat (256) begin @(negedge clk); hi += int'(pwm_l); end
        check("fwd pwm_l highs", hi, 200);

        // Reversal: decel with dirs held, dead time, then reverse ramp.
        state = 3'(BACKWARD);
        wait_zero(500, "bwd decel reaches 0");
        check("bwd dir held", int'(dir_l), 1);
        cyc(500);
        check("bwd dir_l", int'(dir_l), 0);
        check("bwd duty_l", int'(duty_l), 200);

        // Error: immediate zero and brake; recover releases brake next cycle.
        state = 3'(FORWARD);
        cyc(900);
        check("fwd2 duty_l", int'(duty_l), 200);
        state = 3'(ERROR);
        cyc(1);
        check("err duty_l", int'(duty_l), 0);
        check("err duty_r", int'(duty_r), 0);
        check("err pwm", int'({pwm_l, pwm_r}), 0);
        check("err brake", int'(brake), 1);
        state = 3'(RECOVER);
        cyc(1);
        check("recover brake", int'(brake), 0);

        // Stop: brake follows one cycle after both duties hit zero.
        state = 3'(FORWARD);
        cyc(420);
        state = 3'(STOP);
        wait_zero(500, "stop reaches 0");
        check("stop brake at zero", int'(brake), 0);
        cyc(1);
        check("stop brake", int'(brake), 1);
        cyc(5);
        check("stop brake hold", int'(brake), 1);
        state = 3'(IDLE);
        cyc(1);
        check("idle brake off", int'(brake), 0);

        // Left turn, aborted mid dead time by a right turn.
        cyc(10);
        state = 3'(LEFT);
        cyc(20);
        check("left dir_l in dead", int'(dir_l), 1);
        check("left dir_r", int'(dir_r), 1);
        state = 3'(RIGHT);
        cyc(15);
        check("abort dir_l", int'(dir_l), 1);
        check("abort dir_r", int'(dir_r), 1);
        cyc(15);
        check("abort dir_l later", int'(dir_l), 1);
        cyc(600);
        check("right dir_r", int'(dir_r), 0);
        check("right duty_l", int'(duty_l), 128);
        check("right duty_r", int'(duty_r), 128);

        // Exact dead-time length on a reversal from duty 0.
        state = 3'(IDLE);
        cyc(300);
        state = 3'(LEFT);
        cyc(34);
        check("dead edge dir_l before", int'(dir_l), 1);
        cyc(1);
        check("dead edge dir_l after", int'(dir_l), 0);
        check("dead edge dir_r after", int'(dir_r), 1);

        // Enable low forces coast without brake.
        cyc(300);
        enable = 1'b0;
        cyc(1);
        check("disable duty_l", int'(duty_l), 0);
        check("disable brake", int'(brake), 0);
        enable = 1'b1;

        // Random traffic checked by the model only.
        for (int seg = 0; seg < 60; seg++) begin
            state  = 3'($urandom_range(0, 7));
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                cyc($urandom_range(1, 2));
                rst = 1'b0;
            end
            cyc($urandom_range(1, 250));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
